// File: rtl/params_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : params_loader_pkg
//  Description : Shared defines for the parameter loader: word, address and
//                count types, bank geometry and the load range check.
//  Revision    : 1.0 - initial release
// ============================================================================
package params_loader_pkg;

  localparam int PARAM_WIDTH                   = 16;
  localparam int CIM_PARAMS_BANK_SIZE_NUM_WORD = 16;
  localparam int PARAMS_TOTAL_NUM_WORD         = 2 * CIM_PARAMS_BANK_SIZE_NUM_WORD;
  localparam int PARAM_ADDR_WIDTH              = $clog2(PARAMS_TOTAL_NUM_WORD);
  localparam int PARAM_CNT_WIDTH               = PARAM_ADDR_WIDTH + 1;

  typedef logic [PARAM_WIDTH-1:0]      Param_t;
  typedef logic [PARAM_ADDR_WIDTH-1:0] ParamAddr_t;
  typedef logic [PARAM_CNT_WIDTH-1:0]  ParamCnt_t;

  // Total word count at one bit wider than a count, so the end-of-load sum never wraps
  localparam logic [PARAM_CNT_WIDTH:0] TOTAL_WORDS_EXT = PARAMS_TOTAL_NUM_WORD[PARAM_CNT_WIDTH:0];

  // True when a load of num words starting at base would run past the last word
  function automatic logic range_overflow(input ParamAddr_t base, input ParamCnt_t num);
    logic [PARAM_CNT_WIDTH:0] w_end;
    w_end = {2'b00, base} + {1'b0, num};
    return (w_end > TOTAL_WORDS_EXT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/params_loader.sv
`default_nettype none
// ============================================================================
//  Module      : params_loader
//  Description : Streams parameter words from a valid/ready source into the
//                flat two-bank parameter memory, with range check and a
//                running checksum of the accepted words.
//  Revision    : 1.0 - initial release
// ============================================================================
module params_loader
  import params_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  ParamAddr_t base_addr,
  input  ParamCnt_t  num_words,
  input  logic       in_valid,
  input  Param_t     in_data,
  output logic       in_ready,
  output logic       mem_wr_en,
  output ParamAddr_t mem_wr_addr,
  output Param_t     mem_wr_data,
  output logic       mem_chip_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output Param_t     checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  ParamAddr_t r_addr;
  ParamCnt_t  r_remain;
  logic       r_err;
  Param_t     r_checksum;
  logic       r_wr_en;
  ParamAddr_t r_wr_addr;
  Param_t     r_wr_data;

  logic w_hs;
  logic w_start_ok;
  logic w_zero_len;
  logic w_range_err;

  assign w_hs        = in_valid && (r_state == S_LOAD);
  assign w_start_ok  = start && (r_state == S_IDLE);
  assign w_zero_len  = (num_words == '0);
  assign w_range_err = !w_zero_len && range_overflow(base_addr, num_words);

  // Next-state logic: empty or out-of-range loads go straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_zero_len || w_range_err) w_state_nxt = S_DONE;
          else                           w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_hs && (r_remain == ParamCnt_t'(1))) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, checksum and the registered write port; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_remain   <= '0;
      r_err      <= 1'b0;
      r_checksum <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_en   <= w_hs;
      r_wr_addr <= w_hs ? r_addr  : '0;
      r_wr_data <= w_hs ? in_data : '0;
      if (w_start_ok) begin
        r_err      <= w_range_err;
        r_checksum <= '0;
        r_addr     <= base_addr;
        r_remain   <= num_words;
      end else if (w_hs) begin
        r_addr     <= r_addr + ParamAddr_t'(1);
        r_remain   <= r_remain - ParamCnt_t'(1);
        r_checksum <= r_checksum + in_data;
      end
    end
  end

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_chip_en = busy;
  assign err         = r_err;
  assign checksum    = r_checksum;
  assign mem_wr_en   = r_wr_en;
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_params_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_params_loader
//  Description : Self-checking bench for params_loader: directed corner loads
//                plus randomized loads against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_params_loader;
  import params_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  ParamAddr_t base_addr;
  ParamCnt_t  num_words;
  logic       in_valid;
  Param_t     in_data;
  logic       in_ready;
  logic       mem_wr_en;
  ParamAddr_t mem_wr_addr;
  Param_t     mem_wr_data;
  logic       mem_chip_en;
  logic       busy;
  logic       done;
  logic       err;
  Param_t     checksum;

  int total = 0;
  int bad   = 0;

  params_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_chip_en(mem_chip_en), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write log and done-pulse count collected mid-cycle
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  bit          prev_hs  = 1'b0;
  Param_t      word_src[$];

  // Every write must follow a non-reset handshake one cycle earlier; idle write port reads 0
  always @(negedge clk) begin
    if (mon_en) begin
      check("wr_en_follows_hs", 32'(mem_wr_en), 32'(prev_hs));
      check("chip_en_eq_busy", 32'(mem_chip_en), 32'(busy));
      if (mem_wr_en) begin
        addr_q.push_back(32'(mem_wr_addr));
        data_q.push_back(32'(mem_wr_data));
      end else begin
        check("idle_wr_addr", 32'(mem_wr_addr), 32'd0);
        check("idle_wr_data", 32'(mem_wr_data), 32'd0);
      end
      if (done) done_cnt++;
    end
    prev_hs = in_valid && in_ready && rst_n;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"},    32'(mem_wr_en), 32'd0);
    check({tag, "_wr_addr"},  32'(mem_wr_addr), 32'd0);
    check({tag, "_wr_data"},  32'(mem_wr_data), 32'd0);
    check({tag, "_chip_en"},  32'(mem_chip_en), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(done), 32'd0);
    check({tag, "_err"},      32'(err), 32'd0);
    check({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  // mode: 0 back-to-back, 1 valid toggling 1/0, 2 random gaps
  task automatic run_load(input int base, input int num, input int mode, input bit inject);
    int          exp_err;
    int          sent;
    int          cyc;
    bit          v;
    logic [15:0] d;
    logic [15:0] sum;
    logic [15:0] dq[$];
    addr_q.delete();
    data_q.delete();
    done_cnt  = 0;
    base_addr = ParamAddr_t'(base);
    num_words = ParamCnt_t'(num);
    start     = 1'b1;
    step();
    start     = 1'b0;
    exp_err   = (num != 0 && (base + num) > PARAMS_TOTAL_NUM_WORD) ? 1 : 0;
    sum       = 16'd0;
    check("start_err", 32'(err), 32'(exp_err));
    check("start_checksum", 32'(checksum), 32'd0);
    if (num == 0 || exp_err != 0) begin
      check("imm_done", 32'(done), 32'd1);
      check("imm_ready", 32'(in_ready), 32'd0);
      step();
      check("imm_back_idle", 32'(busy), 32'd0);
      check("imm_err_held", 32'(err), 32'(exp_err));
      check("imm_checksum", 32'(checksum), 32'd0);
    end else begin
      sent = 0;
      cyc  = 0;
      while (sent < num && cyc < 400) begin
        check("ready_in_load", 32'(in_ready), 32'd1);
        check("no_early_done", 32'(done), 32'd0);
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        if (v && word_src.size() > 0) d = word_src.pop_front();
        else                          d = 16'($urandom);
        in_valid = v;
        in_data  = d;
        if (inject && cyc == 1) begin
          start     = 1'b1;
          base_addr = ParamAddr_t'($urandom);
          num_words = ParamCnt_t'($urandom_range(1, 5));
        end
        step();
        start = 1'b0;
        if (v) begin
          sent++;
          sum = sum + d;
          dq.push_back(d);
        end
        cyc++;
      end
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      check("load_count", 32'(sent), 32'(num));
      check("done_with_last", 32'(done), 32'd1);
      check("last_wr_in_done", 32'(mem_wr_en), 32'd1);
      check("checksum_at_done", 32'(checksum), 32'(sum));
      step();
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("checksum_stable", 32'(checksum), 32'(sum));
      check("err_clear", 32'(err), 32'd0);
    end
    step();
    check("wr_count", 32'(addr_q.size()), 32'(dq.size()));
    for (int i = 0; i < addr_q.size() && i < dq.size(); i++) begin
      check("wr_addr", addr_q[i], 32'(base + i));
      check("wr_data", data_q[i], 32'(dq[i]));
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int b;
    int n;
    int r;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    step();
    step();
    check_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Four words back-to-back from address 0
    word_src = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_load(0, 4, 0, 1'b0);
    check("sum_1_to_4", 32'(checksum), 32'd10);

    // Bank crossing with toggling valid
    run_load(CIM_PARAMS_BANK_SIZE_NUM_WORD - 2, 4, 1, 1'b0);

    // Out-of-range load: error is sticky across idle cycles, then cleared by a good start
    run_load(PARAMS_TOTAL_NUM_WORD - 1, 2, 0, 1'b0);
    step();
    step();
    check("err_sticky", 32'(err), 32'd1);
    run_load(5, 3, 2, 1'b0);

    // Zero-length load
    run_load(7, 0, 0, 1'b0);

    // Wrap of the checksum with a start pulse injected mid-load
    word_src = '{16'hFFFF, 16'h0002};
    run_load(9, 2, 1, 1'b1);
    check("checksum_wrap", 32'(checksum), 32'h0001);

    // Exact fit to the last word
    run_load(PARAMS_TOTAL_NUM_WORD - 3, 3, 0, 1'b0);

    // Reset after 2 of 5 words, with a handshake coinciding with reset
    addr_q.delete();
    data_q.delete();
    base_addr = ParamAddr_t'(3);
    num_words = ParamCnt_t'(5);
    start     = 1'b1;
    step();
    start     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    step();
    in_data   = 16'h0022;
    step();
    in_data   = 16'h0033;
    rst_n     = 1'b0;
    step();
    check_all_zero("mid_reset");
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    step();
    check("post_reset_no_wr", 32'(mem_wr_en), 32'd0);
    step();
    check("reset_wr_count", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      check("reset_wr_addr0", addr_q[0], 32'd3);
      check("reset_wr_addr1", addr_q[1], 32'd4);
      check("reset_wr_data1", data_q[1], 32'h0022);
    end
    run_load(3, 5, 0, 1'b0);

    // Randomized loads
    for (int t = 0; t < 40; t++) begin
      b = $urandom_range(0, PARAMS_TOTAL_NUM_WORD - 1);
      r = $urandom_range(0, 9);
      if (r == 0)      n = 0;
      else if (r == 1) n = $urandom_range(1, PARAMS_TOTAL_NUM_WORD + 1);
      else             n = $urandom_range(1, PARAMS_TOTAL_NUM_WORD - b);
      run_load(b, n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
